end_screen_reveal_ctrl: RTL and testbench
=========================================

Name: end_screen_reveal_ctrl

Overview:
- Sequences the game-over screen as a timed "typewriter" reveal.
- Order: word 1 ("GAME OVER") letter by letter, then word 2 ("YOUR SCORE") letter by letter, then the score, then word 3 ("PRESS START TO ...").
- Word 3 then blinks until the player presses start.
- Drives the per-word visible-letter counts consumed by the end-screen letter renderers, and issues a one-cycle restart pulse to the game FSM.

Parameters:
- WORD1_SIZE, 9, letters in word 1
- WORD2_SIZE, 10, letters in word 2
- WORD3_SIZE, 16, letters in word 3
- LETTER_FRAMES, 4, frame ticks per revealed letter (>=1)
- SCORE_HOLD_FRAMES, 20, frame ticks the score is shown before word 3 starts (>=1)
- BLINK_FRAMES, 30, frame ticks per half-period of the word-3 blink (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- game_over  in  1  level from game FSM; high while the end screen is required
- frame_tick  in  1  one-cycle strobe at start of each VGA frame
- key_start  in  1  one-cycle start-key pulse (already debounced)
- word1_count  out  5  letters of word 1 to draw (letter i drawn iff i < count)
- word2_count  out  5  same, word 2
- word3_count  out  5  same, word 3
- score_visible  out  1  draw score index and value
- prompt_visible  out  1  word-3 blink gate; renderer ANDs with word3_count
- restart  out  1  one-cycle pulse requesting a new game
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - All counts 0; score_visible, prompt_visible, restart, busy 0.
  - State IDLE, frame counter 0, armed=1.
- States: IDLE, REVEAL1, REVEAL2, SCORE, REVEAL3, WAIT_KEY.
- Outputs are registered; only one frame-tick counter (fcnt) is shared by all states and cleared on every state change.
- IDLE:
  - armed set on any cycle with game_over=0.
  - game_over=1 with armed=1 -> REVEAL1 on the next edge; busy=1 from that edge.
- Letter timing (REVEAL1/2/3):
  - On each frame_tick, fcnt increments.
  - On the tick where fcnt==LETTER_FRAMES-1, fcnt->0 and the state's word count increments.
  - When the increment makes the count equal its SIZE, the state advances on the same edge.
  - Word 1 is complete exactly WORD1_SIZE*LETTER_FRAMES ticks after entry.
  - REVEAL1 -> REVEAL2; REVEAL2 -> SCORE.
- SCORE:
  - score_visible=1 from the entry edge.
  - After SCORE_HOLD_FRAMES ticks -> REVEAL3.
- REVEAL3: prompt_visible=1 throughout; on completion -> WAIT_KEY.
- WAIT_KEY:
  - prompt_visible toggles every BLINK_FRAMES ticks, starting at 1.
  - key_start -> restart=1 for exactly one cycle.
  - Same edge: state IDLE, all counts 0, score_visible=0, prompt_visible=0, armed=0.
- Earlier counts hold at full value in later states (e.g. word1_count=WORD1_SIZE from REVEAL2 onward).
- Skip:
  - key_start in REVEAL1/2/SCORE/REVEAL3 jumps to WAIT_KEY on the next edge.
  - Jump sets all counts to full, score_visible=1, prompt_visible=1, fcnt=0.
  - No restart pulse on a skip; a second key_start is needed to restart.
- Abort:
  - game_over=0 in any non-IDLE state -> IDLE next edge.
  - All outputs cleared, no restart pulse, armed=1.
- Priority on the same cycle: abort > key_start > frame_tick.
- Re-arm: armed=0 after a restart blocks re-entry until game_over has been seen low for at least one cycle, so a lingering game_over cannot replay the screen.
- Async reset mid-sequence returns everything to the reset values immediately.
- Width: counts saturate at their SIZE and never wrap. SIZEs must be <=31; fcnt is wide enough for max(LETTER_FRAMES, SCORE_HOLD_FRAMES, BLINK_FRAMES).

Test Plan:
1. Reset, then game_over=1 and continuous frame_tick every 8 clk (defaults) -> busy next edge; word1_count=1 after 4 ticks, 9 after 36 ticks; word2_count=10 after 76 ticks.
2. Continue scenario 1 -> score_visible rises at tick 76; word3_count starts counting at tick 96; WAIT_KEY reached at tick 160; prompt_visible low at tick 190, high again at 220.
3. In WAIT_KEY, key_start one cycle -> restart high exactly one cycle, all outputs 0; game_over held 1 keeps state IDLE; game_over 0 then 1 -> REVEAL1 again.
4. key_start during REVEAL1 at word1_count=3 -> next edge counts 9/10/16, score_visible=1, prompt_visible=1, restart=0; second key_start -> restart pulse.
5. game_over dropped during SCORE -> next edge all outputs 0, busy=0; game_over reasserted -> reveal restarts from word1_count=0.
6. Same-cycle key_start and frame_tick in REVEAL2 -> skip taken, no count increment, fcnt=0. Same-cycle game_over=0 with key_start in WAIT_KEY -> abort, restart stays 0.

Source files
------------

// File: rtl/end_screen_reveal_ctrl.sv
// Game-over screen sequencer: typewriter reveal of three words and the score,
// then a blinking prompt until start is pressed, followed by a one-cycle restart pulse.
module end_screen_reveal_ctrl #(
  parameter int unsigned WORD1_SIZE        = 9,
  parameter int unsigned WORD2_SIZE        = 10,
  parameter int unsigned WORD3_SIZE        = 16,
  parameter int unsigned LETTER_FRAMES     = 4,
  parameter int unsigned SCORE_HOLD_FRAMES = 20,
  parameter int unsigned BLINK_FRAMES      = 30
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       game_over_i,
  input  logic       frame_tick_i,
  input  logic       key_start_i,
  output logic [4:0] word1_count_o,
  output logic [4:0] word2_count_o,
  output logic [4:0] word3_count_o,
  output logic       score_visible_o,
  output logic       prompt_visible_o,
  output logic       restart_o,
  output logic       busy_o
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned FMAX_A = (LETTER_FRAMES > SCORE_HOLD_FRAMES) ? LETTER_FRAMES
                                                                       : SCORE_HOLD_FRAMES;
  localparam int unsigned FMAX   = (FMAX_A > BLINK_FRAMES) ? FMAX_A : BLINK_FRAMES;
  localparam int unsigned FCNT_W = (FMAX < 2) ? 1 : $clog2(FMAX + 1);

  localparam logic [CNT_W-1:0]  W1_FULL    = CNT_W'(WORD1_SIZE);
  localparam logic [CNT_W-1:0]  W2_FULL    = CNT_W'(WORD2_SIZE);
  localparam logic [CNT_W-1:0]  W3_FULL    = CNT_W'(WORD3_SIZE);
  localparam logic [FCNT_W-1:0] LETTER_END = FCNT_W'(LETTER_FRAMES - 1);
  localparam logic [FCNT_W-1:0] SCORE_END  = FCNT_W'(SCORE_HOLD_FRAMES - 1);
  localparam logic [FCNT_W-1:0] BLINK_END  = FCNT_W'(BLINK_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REVEAL1  = 3'd1,
    REVEAL2  = 3'd2,
    SCORE    = 3'd3,
    REVEAL3  = 3'd4,
    WAIT_KEY = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  w1_q, w1_d;
  logic [CNT_W-1:0]  w2_q, w2_d;
  logic [CNT_W-1:0]  w3_q, w3_d;
  logic              score_vis_q, score_vis_d;
  logic              prompt_vis_q, prompt_vis_d;
  logic              restart_q, restart_d;
  logic              busy_q, busy_d;
  logic              armed_q, armed_d;
  logic              letter_done;

  assign letter_done = frame_tick_i && (fcnt_q == LETTER_END);

  // Next-state and next-output logic; priority is abort > key_start > frame_tick.
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    w1_d         = w1_q;
    w2_d         = w2_q;
    w3_d         = w3_q;
    score_vis_d  = score_vis_q;
    prompt_vis_d = prompt_vis_q;
    restart_d    = 1'b0;
    busy_d       = busy_q;
    armed_d      = armed_q;

    if (state_q == IDLE) begin
      if (!game_over_i) begin
        armed_d = 1'b1;
      end else if (armed_q) begin
        state_d = REVEAL1;
        fcnt_d  = '0;
        busy_d  = 1'b1;
      end
    end else if (!game_over_i) begin
      state_d      = IDLE;
      fcnt_d       = '0;
      w1_d         = '0;
      w2_d         = '0;
      w3_d         = '0;
      score_vis_d  = 1'b0;
      prompt_vis_d = 1'b0;
      busy_d       = 1'b0;
      armed_d      = 1'b1;
    end else if (key_start_i) begin
      fcnt_d = '0;
      if (state_q == WAIT_KEY) begin
        state_d      = IDLE;
        w1_d         = '0;
        w2_d         = '0;
        w3_d         = '0;
        score_vis_d  = 1'b0;
        prompt_vis_d = 1'b0;
        restart_d    = 1'b1;
        busy_d       = 1'b0;
        armed_d      = 1'b0;
      end else begin
        state_d      = WAIT_KEY;
        w1_d         = W1_FULL;
        w2_d         = W2_FULL;
        w3_d         = W3_FULL;
        score_vis_d  = 1'b1;
        prompt_vis_d = 1'b1;
      end
    end else if (frame_tick_i) begin
      fcnt_d = fcnt_q + FCNT_W'(1);
      case (state_q)
        REVEAL1: begin
          if (letter_done) begin
            fcnt_d = '0;
            w1_d   = w1_q + CNT_W'(1);
            if (w1_d == W1_FULL) state_d = REVEAL2;
          end
        end
        REVEAL2: begin
          if (letter_done) begin
            fcnt_d = '0;
            w2_d   = w2_q + CNT_W'(1);
            if (w2_d == W2_FULL) begin
              state_d     = SCORE;
              score_vis_d = 1'b1;
            end
          end
        end
        SCORE: begin
          if (fcnt_q == SCORE_END) begin
            fcnt_d       = '0;
            state_d      = REVEAL3;
            prompt_vis_d = 1'b1;
          end
        end
        REVEAL3: begin
          if (letter_done) begin
            fcnt_d = '0;
            w3_d   = w3_q + CNT_W'(1);
            if (w3_d == W3_FULL) state_d = WAIT_KEY;
          end
        end
        WAIT_KEY: begin
          if (fcnt_q == BLINK_END) begin
            fcnt_d       = '0;
            prompt_vis_d = ~prompt_vis_q;
          end
        end
        default: begin
          fcnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      fcnt_q       <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      w3_q         <= '0;
      score_vis_q  <= 1'b0;
      prompt_vis_q <= 1'b0;
      restart_q    <= 1'b0;
      busy_q       <= 1'b0;
      armed_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      w3_q         <= w3_d;
      score_vis_q  <= score_vis_d;
      prompt_vis_q <= prompt_vis_d;
      restart_q    <= restart_d;
      busy_q       <= busy_d;
      armed_q      <= armed_d;
    end
  end

  assign word1_count_o    = w1_q;
  assign word2_count_o    = w2_q;
  assign word3_count_o    = w3_q;
  assign score_visible_o  = score_vis_q;
  assign prompt_visible_o = prompt_vis_q;
  assign restart_o        = restart_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_end_screen_reveal_ctrl.sv
// Bench for end_screen_reveal_ctrl: directed scenarios plus random stimulus against
// a timeline model that derives every output from ticks elapsed since the reveal began.
module tb_end_screen_reveal_ctrl;

  localparam int W1 = 9;
  localparam int W2 = 10;
  localparam int W3 = 16;
  localparam int LF = 4;
  localparam int SH = 20;
  localparam int BF = 30;

  // Reveal timeline in frame ticks from entry.
  localparam int T1 = W1 * LF;
  localparam int T2 = T1 + W2 * LF;
  localparam int T3 = T2 + SH;
  localparam int T4 = T3 + W3 * LF;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       game_over = 1'b0;
  logic       frame_tick = 1'b0;
  logic       key_start = 1'b0;
  logic [4:0] word1_count, word2_count, word3_count;
  logic       score_visible, prompt_visible, restart, busy;

  end_screen_reveal_ctrl dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .game_over_i      (game_over),
    .frame_tick_i     (frame_tick),
    .key_start_i      (key_start),
    .word1_count_o    (word1_count),
    .word2_count_o    (word2_count),
    .word3_count_o    (word3_count),
    .score_visible_o  (score_visible),
    .prompt_visible_o (prompt_visible),
    .restart_o        (restart),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: 0 = idle, 1 = revealing (m_t ticks since entry), 2 = waiting for key (m_u ticks).
  int m_mode = 0;
  int m_t = 0;
  int m_u = 0;
  bit m_armed = 1'b1;
  bit m_restart = 1'b0;

  function automatic int sat(int v, int hi);
    return (v > hi) ? hi : ((v < 0) ? 0 : v);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_u = 0; m_armed = 1'b1; m_restart = 1'b0;
  endtask

  task automatic model_step(input bit g, input bit t, input bit k);
    m_restart = 1'b0;
    if (m_mode == 0) begin
      if (!g) m_armed = 1'b1;
      else if (m_armed) begin m_mode = 1; m_t = 0; end
    end else if (!g) begin
      m_mode = 0; m_armed = 1'b1;
    end else if (k) begin
      if (m_mode == 2) begin m_mode = 0; m_restart = 1'b1; m_armed = 1'b0; end
      else begin m_mode = 2; m_u = 0; end
    end else if (t) begin
      if (m_mode == 1) begin
        m_t++;
        if (m_t == T4) begin m_mode = 2; m_u = 0; end
      end else begin
        m_u++;
      end
    end
  endtask

  task automatic check_all();
    int e1, e2, e3, esv, epv, ebusy;
    e1 = 0; e2 = 0; e3 = 0; esv = 0; epv = 0; ebusy = 0;
    if (m_mode == 1) begin
      e1 = sat(m_t / LF, W1);
      e2 = (m_t < T1) ? 0 : sat((m_t - T1) / LF, W2);
      esv = (m_t >= T2) ? 1 : 0;
      e3 = (m_t < T3) ? 0 : sat((m_t - T3) / LF, W3);
      epv = (m_t >= T3) ? 1 : 0;
      ebusy = 1;
    end else if (m_mode == 2) begin
      e1 = W1; e2 = W2; e3 = W3; esv = 1; ebusy = 1;
      epv = (((m_u / BF) % 2) == 0) ? 1 : 0;
    end
    check("word1_count", 32'(word1_count), 32'(e1));
    check("word2_count", 32'(word2_count), 32'(e2));
    check("word3_count", 32'(word3_count), 32'(e3));
    check("score_visible", 32'(score_visible), 32'(esv));
    check("prompt_visible", 32'(prompt_visible), 32'(epv));
    check("restart", 32'(restart), 32'(m_restart));
    check("busy", 32'(busy), 32'(ebusy));
  endtask

  task automatic step(input bit g, input bit t, input bit k);
    game_over = g; frame_tick = t; key_start = k;
    @(posedge clk);
    model_step(g, t, k);
    #1;
    check_all();
  endtask

  // One frame tick followed by seven quiet cycles, game_over held high.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, 1'b0);
      repeat (7) step(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_w1", 32'(word1_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // Scenario 1/2: full reveal with a tick every 8 clocks.
    step(1'b1, 1'b0, 1'b0);
    check("s1_busy_entry", 32'(busy), 32'd1);
    frames(4);
    check("s1_w1_at4", 32'(word1_count), 32'd1);
    frames(32);
    check("s1_w1_at36", 32'(word1_count), 32'd9);
    frames(40);
    check("s1_w2_at76", 32'(word2_count), 32'd10);
    check("s2_score_at76", 32'(score_visible), 32'd1);
    frames(20);
    check("s2_pv_at96", 32'(prompt_visible), 32'd1);
    check("s2_w3_at96", 32'(word3_count), 32'd0);
    frames(4);
    check("s2_w3_at100", 32'(word3_count), 32'd1);
    frames(60);
    check("s2_w3_at160", 32'(word3_count), 32'd16);
    frames(30);
    check("s2_pv_at190", 32'(prompt_visible), 32'd0);
    frames(30);
    check("s2_pv_at220", 32'(prompt_visible), 32'd1);

    // Scenario 3: restart pulse and re-arm.
    step(1'b1, 1'b0, 1'b1);
    check("s3_restart", 32'(restart), 32'd1);
    check("s3_w3_clear", 32'(word3_count), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("s3_restart_once", 32'(restart), 32'd0);
    repeat (5) step(1'b1, 1'b1, 1'b0);
    check("s3_stays_idle", 32'(busy), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("s3_rearm_entry", 32'(busy), 32'd1);

    // Scenario 4: skip at word1_count=3, then restart.
    frames(12);
    check("s4_w1_before", 32'(word1_count), 32'd3);
    step(1'b1, 1'b0, 1'b1);
    check("s4_skip_w2", 32'(word2_count), 32'd10);
    check("s4_skip_w3", 32'(word3_count), 32'd16);
    check("s4_skip_norestart", 32'(restart), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    check("s4_restart", 32'(restart), 32'd1);

    // Scenario 5: abort during SCORE, then a fresh reveal.
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    frames(80);
    check("s5_in_score", 32'(score_visible), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("s5_abort_busy", 32'(busy), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("s5_reentry_w1", 32'(word1_count), 32'd0);

    // Scenario 6: key and tick together in REVEAL2; abort beats key in WAIT_KEY.
    frames(41);
    step(1'b1, 1'b1, 1'b1);
    check("s6_skip_pv", 32'(prompt_visible), 32'd1);
    frames(30);
    check("s6_blink_from_zero", 32'(prompt_visible), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check("s6_abort_norestart", 32'(restart), 32'd0);
    check("s6_abort_busy", 32'(busy), 32'd0);

    // Mid-sequence async reset.
    step(1'b1, 1'b0, 1'b0);
    frames(10);
    pulse_reset();
    step(1'b1, 1'b0, 1'b0);

    // Random phase.
    for (int i = 0; i < 6000; i++) begin
      bit g, t, k;
      g = ($urandom_range(0, 299) != 0);
      if (($urandom_range(0, 999) < 3) && !game_over) g = 1'b0;
      t = ($urandom_range(0, 3) == 0);
      k = ($urandom_range(0, 179) == 0);
      if ($urandom_range(0, 2999) == 0) pulse_reset();
      step(g, t, k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
